instr_fetch_unit: RTL and testbench

//  Instruction fetch stage of the MIPS datapath: holds the PC, reads instruction memory through a
//  req/ack handshake and latches the word into the instruction register. instr[31:0] feeds the

---
 rtl/instr_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction fetch stage. Holds the PC and reads one word from instruction
//   memory over a req/ack handshake. The returned word is latched into the
//   instruction register together with its address and address + 4. It is
//   presented to the field splitter until downstream takes it (instr_valid_o
//   high and stall_i low). A branch/jump redirect reloads the PC from any state.
//
// Optional feature (compile-time macro FETCH_ALIGN_CHECK_EN):
//   defined   : a redirect whose target has nonzero low bits sets the sticky
//               fetch_misalign_o flag. The flag stays set until reset.
//   undefined : fetch_misalign_o is tied low and no check logic is built.
//   In both builds the PC loads the word-aligned target.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous reset, active-high
//   imem_req_o       instruction memory read request
//   imem_addr_o      byte address of requested word (= pc)
//   imem_ack_i       memory returns imem_rdata_i this cycle
//   imem_rdata_i     instruction word, valid with imem_ack_i
//   stall_i          downstream not ready, hold current instruction
//   redirect_i       load redirect_pc_i (branch/jump taken)
//   redirect_pc_i    new PC
//   instr_o          instruction register
//   instr_pc_o       address of instr_o
//   pc_plus4_o       instr_pc_o + 4 (registered)
//   instr_valid_o    instr_o holds a valid, unconsumed instruction
//   fetch_misalign_o sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        instr_valid_o,
    output logic        fetch_misalign_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StValid = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_inc;

    // 32-bit wrap at the top of the address space is intended.
    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;

        if (redirect_i) begin
            // Redirect beats everything: a word returned this cycle is
            // discarded, and so is a stalled instruction. The old instr
            // contents stay visible but are marked invalid.
            pc_d    = {redirect_pc_i[31:2], 2'b00};
            valid_d = 1'b0;
            state_d = StFetch;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StFetch;
                end
                StFetch: begin
                    if (imem_ack_i) begin
                        instr_d    = imem_rdata_i;
                        instr_pc_d = pc_q;
                        pc_plus4_d = pc_inc;
                        pc_d       = pc_inc;
                        valid_d    = 1'b1;
                        state_d    = StValid;
                    end
                end
                StValid: begin
                    if (!stall_i) begin
                        valid_d = 1'b0;
                        state_d = StFetch;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            pc_q       <= {PC_RESET[31:2], 2'b00};
            instr_q    <= '0;
            instr_pc_q <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    // The request is decoded from the registered state, so it is low in reset.
    assign imem_req_o    = (state_q == StFetch);
    assign imem_addr_o   = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign pc_plus4_o    = pc_plus4_q;
    assign instr_valid_o = valid_q;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = misalign_q;
        if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign fetch_misalign_o = misalign_q;
`else
    // The low target bits are dropped on purpose in this build.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];
    assign fetch_misalign_o    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ack, stall, redirect;
    logic [31:0] rdata, rpc;
    logic        req, valid, misalign;
    logic [31:0] addr, instr, instr_pc, pc_plus4;

    // Second instance exercising the PC wrap from the top of memory.
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_req, w_valid, w_misalign;
    logic [31:0] w_addr, w_instr, w_instr_pc, w_pc_plus4;

    int total = 0;
    int bad   = 0;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic MIS_EXP = 1'b1;
`else
    localparam logic MIS_EXP = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb_q[$];
    bit   seen = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.PC_RESET(32'h0000_0000)) u_dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .imem_req_o      (req),
        .imem_addr_o     (addr),
        .imem_ack_i      (ack),
        .imem_rdata_i    (rdata),
        .stall_i         (stall),
        .redirect_i      (redirect),
        .redirect_pc_i   (rpc),
        .instr_o         (instr),
        .instr_pc_o      (instr_pc),
        .pc_plus4_o      (pc_plus4),
        .instr_valid_o   (valid),
        .fetch_misalign_o(misalign)
    );

    instr_fetch_unit #(.PC_RESET(32'hFFFF_FFFC)) u_wrap (
        .clk_i           (clk),
        .rst_i           (rst),
        .imem_req_o      (w_req),
        .imem_addr_o     (w_addr),
        .imem_ack_i      (w_ack),
        .imem_rdata_i    (w_rdata),
        .stall_i         (1'b0),
        .redirect_i      (1'b0),
        .redirect_pc_i   (32'h0),
        .instr_o         (w_instr),
        .instr_pc_o      (w_instr_pc),
        .pc_plus4_o      (w_pc_plus4),
        .instr_valid_o   (w_valid),
        .fetch_misalign_o(w_misalign)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard once per presented instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                seen = 1'b0;
            end else begin
                if (valid && !seen) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected: got instr %h at %h expected none",
                                 instr, instr_pc);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_instr", instr, e.instr);
                        check("sb_instr_pc", instr_pc, e.pc);
                        check("sb_pc_plus4", pc_plus4, e.pc4);
                    end
                end
                seen = valid && stall;
            end
        end
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL req_timeout: got req=0 expected req=1 within 20 cycles");
        end
    endtask

    // Answer one request after lat wait cycles; returns on the negedge where
    // the captured instruction is presented.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int lat,
                         input logic stall_after);
        bit ok;
        exp_t e;
        wait_req(ok);
        if (!ok) return;
        check("req_addr", addr, a);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("req_held", {31'b0, req}, 32'd1);
            check("addr_held", addr, a);
            check("valid_low_wait", {31'b0, valid}, 32'd0);
        end
        e.instr = d;
        e.pc    = a;
        e.pc4   = a + 32'd4;
        sb_q.push_back(e);
        ack   = 1'b1;
        rdata = d;
        stall = stall_after;
        @(negedge clk);
        ack   = 1'b0;
        rdata = '0;
    endtask

    initial begin
        bit ok;
        rst = 1'b1; ack = 1'b0; stall = 1'b0; redirect = 1'b0;
        rdata = '0; rpc = '0; w_ack = 1'b0; w_rdata = '0;

        repeat (2) @(negedge clk);
        check("rst_req", {31'b0, req}, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_misalign", {31'b0, misalign}, 32'd0);
        rst = 1'b0;
        check("idle_bubble", {31'b0, req}, 32'd0);

        // First fetch, then stall for 5 cycles in the valid state.
        fetch(32'h0, 32'h2008_0005, 1, 1'b1);
        check("t1_valid", {31'b0, valid}, 32'd1);
        check("t1_pc_plus4", pc_plus4, 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'b0, valid}, 32'd1);
            check("stall_instr", instr, 32'h2008_0005);
            check("stall_instr_pc", instr_pc, 32'h0);
            check("stall_req", {31'b0, req}, 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        check("next_req", {31'b0, req}, 32'd1);
        check("next_addr", addr, 32'h4);

        // Three-cycle memory latency.
        fetch(32'h4, 32'h8C09_0000, 3, 1'b0);

        // Redirect coincident with ack drops the returned word.
        wait_req(ok);
        check("t4_addr", addr, 32'h8);
        ack = 1'b1; rdata = 32'hDEAD_BEEF; redirect = 1'b1; rpc = 32'h40;
        @(negedge clk);
        ack = 1'b0; rdata = '0; redirect = 1'b0;
        check("t4_valid", {31'b0, valid}, 32'd0);
        check("t4_req", {31'b0, req}, 32'd1);
        check("t4_addr_redir", addr, 32'h40);
        repeat (2) @(negedge clk);
        check("t4_valid_hold", {31'b0, valid}, 32'd0);
        fetch(32'h40, 32'h0128_5020, 0, 1'b0);

        // Misaligned redirect while waiting on memory.
        @(negedge clk);
        check("t6_pre_addr", addr, 32'h44);
        redirect = 1'b1; rpc = 32'h42;
        @(negedge clk);
        redirect = 1'b0; rpc = '0;
        check("t6_addr", addr, 32'h40);
        check("t6_misalign", {31'b0, misalign}, {31'b0, MIS_EXP});
        fetch(32'h40, 32'h1000_FFFF, 1, 1'b0);
        check("t6_sticky", {31'b0, misalign}, {31'b0, MIS_EXP});

        // Asynchronous reset in the middle of a fetch.
        @(negedge clk);
        check("t6_mid_req", {31'b0, req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_req", {31'b0, req}, 32'd0);
        check("arst_valid", {31'b0, valid}, 32'd0);
        check("arst_instr", instr, 32'd0);
        check("arst_instr_pc", instr_pc, 32'd0);
        check("arst_pc_plus4", pc_plus4, 32'd0);
        check("arst_misalign", {31'b0, misalign}, 32'd0);
        check("arst_addr", addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // PC wrap on the second instance.
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (w_req) begin
                ok = 1'b1;
                break;
            end
        end
        check("wrap_req_seen", {31'b0, ok}, 32'd1);
        check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        w_ack = 1'b1; w_rdata = 32'h0800_0000;
        @(negedge clk);
        w_ack = 1'b0; w_rdata = '0;
        check("wrap_valid", {31'b0, w_valid}, 32'd1);
        check("wrap_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", w_pc_plus4, 32'h0);
        @(negedge clk);
        check("wrap_req1", {31'b0, w_req}, 32'd1);
        check("wrap_addr1", w_addr, 32'h0);

        // Main instance recovered from reset at PC_RESET.
        fetch(32'h0, 32'h2008_0005, 0, 1'b0);
        #2;
        check("sb_drained", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
